// File: rtl/if_write_addr_gen_pkg.sv
// Shared types for the IF scratchpad write address generator.
package if_write_addr_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } wr_state_t;

endpackage

// File: rtl/if_ptr_wrap.sv
// Circular pointer add: (base + offset) mod IF_SCRATCH_DEPTH.
module if_ptr_wrap
  import if_write_addr_gen_pkg::*;
#(
  parameter int IF_ADDR_LEN      = 4,
  parameter int IF_SCRATCH_DEPTH = 16
) (
  input  logic [IF_ADDR_LEN-1:0] base,
  input  logic [IF_ADDR_LEN-1:0] offset,
  output logic [IF_ADDR_LEN-1:0] sum
);

  localparam logic [IF_ADDR_LEN:0] DEPTH_W =
    (IF_ADDR_LEN+1)'(IF_SCRATCH_DEPTH);

  logic [IF_ADDR_LEN:0] raw;

  // Both operands are below DEPTH, so one conditional subtract wraps.
  assign raw = {1'b0, base} + {1'b0, offset};
  assign sum = IF_ADDR_LEN'((raw >= DEPTH_W) ? raw - DEPTH_W : raw);

endmodule

// File: rtl/if_write_addr_gen.sv
// Write-side address generator for the circular IF scratchpad.
module if_write_addr_gen
  import if_write_addr_gen_pkg::*;
#(
  parameter int IF_ADDR_LEN      = 4,
  parameter int IF_SCRATCH_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   IF_in_valid,
  input  logic                   IF_in_last,
  input  logic                   full_done,
  output logic                   IF_in_ready,
  output logic                   IF_wen,
  output logic [IF_ADDR_LEN-1:0] IF_waddr,
  output logic [IF_ADDR_LEN-1:0] IF_start_pos,
  output logic [IF_ADDR_LEN-1:0] IF_end_pos,
  output logic                   IF_end_valid,
  output logic                   scratch_full
);

  localparam logic [IF_ADDR_LEN-1:0] FULL_CNT =
    IF_ADDR_LEN'(IF_SCRATCH_DEPTH-1);
  localparam logic [IF_ADDR_LEN-1:0] ONE = IF_ADDR_LEN'(1);

  wr_state_t              state;
  logic [IF_ADDR_LEN-1:0] count;
  logic [IF_ADDR_LEN-1:0] next_start;

  if_ptr_wrap #(
    .IF_ADDR_LEN     (IF_ADDR_LEN),
    .IF_SCRATCH_DEPTH(IF_SCRATCH_DEPTH)
  ) u_waddr (
    .base  (IF_start_pos),
    .offset(count),
    .sum   (IF_waddr)
  );

  if_ptr_wrap #(
    .IF_ADDR_LEN     (IF_ADDR_LEN),
    .IF_SCRATCH_DEPTH(IF_SCRATCH_DEPTH)
  ) u_next_start (
    .base  (IF_end_pos),
    .offset(ONE),
    .sum   (next_start)
  );

  assign scratch_full = (count == FULL_CNT);
  // Reset blocks a same-cycle write so a dropped row leaves no trace.
  assign IF_in_ready  = (state == FILL) & ~scratch_full & ~rst;
  assign IF_wen       = IF_in_valid & IF_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      IF_start_pos <= '0;
      IF_end_pos   <= '0;
      IF_end_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) state <= FILL;
        end
        FILL: begin
          if (IF_wen) begin
            count <= count + ONE;
            if (IF_in_last) begin
              IF_end_pos   <= IF_waddr;
              IF_end_valid <= 1'b1;
              state        <= HOLD;
            end
          end
        end
        HOLD: begin
          if (full_done) begin
            IF_start_pos <= next_start;
            count        <= '0;
            IF_end_valid <= 1'b0;
            state        <= FILL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/if_write_addr_gen.md
IF_WRITE_ADDR_GEN -- requirements
Module: if_write_addr_gen

Interface
REQ-001 SHALL have parameter IF_ADDR_LEN, default 4, meaning the width of IF scratchpad addresses.
REQ-002 SHALL have parameter IF_SCRATCH_DEPTH, default 16, meaning the number of IF scratchpad entries; it is at most 2^IF_ADDR_LEN.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begins filling the first row.
REQ-006 SHALL have port IF_in_valid, input, 1 bit: an upstream IF word is present.
REQ-007 SHALL have port IF_in_last, input, 1 bit: the current word is the last of its row; qualified by IF_in_valid.
REQ-008 SHALL have port full_done, input, 1 bit: single-cycle pulse from the read address generator; the current row is fully consumed.
REQ-009 SHALL have port IF_in_ready, output, 1 bit: a write is accepted this cycle.
REQ-010 SHALL have port IF_wen, output, 1 bit: the scratchpad write enable.
REQ-011 SHALL have port IF_waddr, output, IF_ADDR_LEN bits: the next write location, (IF_start_pos + count) mod IF_SCRATCH_DEPTH.
REQ-012 SHALL have port IF_start_pos, output, IF_ADDR_LEN bits: the address of the first word of the current row.
REQ-013 SHALL have port IF_end_pos, output, IF_ADDR_LEN bits: the address of the last word of the current row; valid only while IF_end_valid is high.
REQ-014 SHALL have port IF_end_valid, output, 1 bit: the last word of the row has been written.
REQ-015 SHALL have port scratch_full, output, 1 bit: occupancy has reached IF_SCRATCH_DEPTH-1.

Function
REQ-016 SHALL implement FSM states IDLE, FILL and HOLD.
REQ-017 SHALL make the IDLE->FILL transition when start=1; while in IDLE, IF_in_ready=0.
REQ-018 SHALL set IF_in_ready = (state==FILL) & ~scratch_full, combinationally.
REQ-019 SHALL assert IF_wen = IF_in_valid & IF_in_ready in the same cycle (zero latency); the write data address is the current IF_waddr.
REQ-020 SHALL, on each accepted write, increment count by 1; IF_waddr therefore advances modulo IF_SCRATCH_DEPTH and wraps from DEPTH-1 to 0.
REQ-021 SHALL limit occupancy to at most IF_SCRATCH_DEPTH-1 words, so that IF_waddr never equals IF_start_pos while data is held; scratch_full = (count == IF_SCRATCH_DEPTH-1).
REQ-022 SHALL, on an accepted write with IF_in_last=1, register IF_end_pos <= current IF_waddr and IF_end_valid <= 1, and enter HOLD on the next cycle.
REQ-023 SHALL keep IF_in_ready=0 in HOLD; IF_in_valid is ignored there.
REQ-024 SHALL, on full_done=1 in HOLD, perform the following on the next edge: IF_start_pos <= (IF_end_pos+1) mod DEPTH, count <= 0, IF_end_valid <= 0, state <= FILL.
REQ-025 SHALL ignore full_done in IDLE and FILL, with no state change.
REQ-026 SHALL compute all modulo arithmetic at IF_ADDR_LEN+1 bits before reduction; no intermediate result is truncated before the modulo.
REQ-027 SHALL, if IF_in_last arrives on the write that reaches scratch_full, still take that write; the HOLD transition has priority.
REQ-028 SHALL keep IF_end_pos stable while IF_end_valid=1.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, set state=IDLE, count=0, IF_start_pos=0, IF_end_pos=0, IF_end_valid=0; consequently IF_in_ready=0, IF_wen=0, IF_waddr=0 and scratch_full=0.
REQ-030 SHALL give rst priority over every other input, including a simultaneous write or full_done; a reset mid-row discards the row.

Structure
REQ-031 SHALL place the FSM state encoding (IDLE=2'd0, FILL=2'd1, HOLD=2'd2) in the shared package.
REQ-032 SHALL use one sub-module, if_ptr_wrap, which computes (base + offset) mod IF_SCRATCH_DEPTH; it is instantiated for IF_waddr and for the next IF_start_pos.

Verification (DEPTH=8, IF_ADDR_LEN=3)
REQ-033 SHALL cover: start, then 5 valid words with last on the 5th -> IF_waddr steps 0..5, IF_end_pos=4, IF_end_valid=1, IF_in_ready=0.
REQ-034 SHALL cover: in HOLD, pulse full_done -> next cycle IF_start_pos=5, IF_waddr=5, IF_end_valid=0, state FILL.
REQ-035 SHALL cover: from start_pos=5, 7 words with no last -> IF_waddr wraps 5,6,7,0,1,2,3, then 4; scratch_full=1; the 8th valid word is not accepted (IF_wen=0).
REQ-036 SHALL cover: the 7th word carries last while the buffer reaches full -> the write is taken, IF_end_pos=3, HOLD entered.
REQ-037 SHALL cover: rst asserted mid-FILL with IF_in_valid=1 -> no write that cycle; next cycle all outputs equal the reset values of REQ-029.
REQ-038 SHALL cover: full_done pulsed during FILL -> ignored; IF_start_pos and count unchanged.
